// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W     = 4;
    localparam int ADD3_THRESH = 5;
    localparam int ADD3_VALUE  = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(ADD3_THRESH)) begin
            digit_out = digit_in + DIGIT_W'(ADD3_VALUE);
        end
    end

endmodule

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock,
// saturating to all nines when the value does not fit in DIGITS digits.
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           binary,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd_out,
    output logic                       overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam int BW = DIGIT_W * DIGITS;
    localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]   acc, adj, acc_next;
    logic            ovf_track, ovf_next;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc[i*DIGIT_W +: DIGIT_W]),
            .digit_out (adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    // Bit leaving the top digit means the value no longer fits.
    always_comb begin
        acc_next = {adj[BW-2:0], shreg[WIDTH-1]};
        ovf_next = ovf_track | adj[BW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (count == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The final iteration and the result load share the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            shreg     <= '0;
            acc       <= '0;
            ovf_track <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg     <= binary;
                        acc       <= '0;
                        ovf_track <= 1'b0;
                        count     <= CW'(WIDTH - 1);
                    end
                end
                ST_SHIFT: begin
                    shreg     <= {shreg[WIDTH-2:0], 1'b0};
                    acc       <= acc_next;
                    ovf_track <= ovf_next;
                    if (count == '0) begin
                        bcd_out  <= ovf_next ? NINES : acc_next;
                        overflow <= ovf_next;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Randomized self-checking bench for bcd_converter_seq against a decimal-arithmetic model.
module tb_bcd_converter_seq;

    localparam int W_A = 16, D_A = 5;
    localparam int W_B = 16, D_B = 3;
    localparam int W_C = 8,  D_C = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic             start_a = 1'b0;
    logic [W_A-1:0]   bin_a = '0;
    logic             busy_a, done_a, ovf_a;
    logic [4*D_A-1:0] bcd_a;

    logic             start_b = 1'b0;
    logic [W_B-1:0]   bin_b = '0;
    logic             busy_b, done_b, ovf_b;
    logic [4*D_B-1:0] bcd_b;

    logic             start_c = 1'b0;
    logic [W_C-1:0]   bin_c = '0;
    logic             busy_c, done_c, ovf_c;
    logic [4*D_C-1:0] bcd_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_converter_seq #(.WIDTH(W_A), .DIGITS(D_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
    );

    bcd_converter_seq #(.WIDTH(W_B), .DIGITS(D_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
    );

    bcd_converter_seq #(.WIDTH(W_C), .DIGITS(D_C)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .binary(bin_c),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned pow10(input int digits);
        longint unsigned p = 1;
        for (int i = 0; i < digits; i++) p *= 10;
        return p;
    endfunction

    function automatic logic [63:0] ref_bcd(input longint unsigned value, input int digits);
        logic [63:0] r = '0;
        longint unsigned v = value;
        if (v >= pow10(digits)) begin
            for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
        end else begin
            for (int i = 0; i < digits; i++) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned value, input int digits);
        return value >= pow10(digits);
    endfunction

    // n counts edges from the accepting edge (counted as 1) to the done sample.
    task automatic conv_a(input logic [W_A-1:0] v, input bit repulse, input string tag);
        int n;
        @(negedge clk);
        bin_a   = v;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = W_A'($urandom);
        n = 1;
        check({tag, "_busy"}, 64'(busy_a), 64'd1);
        while (!done_a && n < 60) begin
            if (repulse && n == 5) begin
                start_a = 1'b1;
                bin_a   = W_A'(7);
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(W_A + 1));
        check({tag, "_bcd"}, 64'(bcd_a), ref_bcd(64'(v), D_A));
        check({tag, "_ovf"}, 64'(ovf_a), 64'(ref_ovf(64'(v), D_A)));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done_a), 64'd0);
        check({tag, "_idle"}, 64'(busy_a), 64'd0);
        bin_a = W_A'($urandom);
        repeat (W_A + 4) @(negedge clk);
        check({tag, "_no_second_done"}, 64'(done_a), 64'd0);
        check({tag, "_hold"}, 64'(bcd_a), ref_bcd(64'(v), D_A));
    endtask

    task automatic conv_b(input logic [W_B-1:0] v, input string tag);
        int n;
        @(negedge clk);
        bin_b   = v;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(W_B + 1));
        check({tag, "_bcd"}, 64'(bcd_b), ref_bcd(64'(v), D_B));
        check({tag, "_ovf"}, 64'(ovf_b), 64'(ref_ovf(64'(v), D_B)));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done_b), 64'd0);
    endtask

    initial begin
        bit saw_done;
        int n;

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy_a), 64'd0);
        check("reset_done", 64'(done_a), 64'd0);
        check("reset_bcd", 64'(bcd_a), 64'd0);
        check("reset_ovf", 64'(ovf_a), 64'd0);
        rst_n = 1'b1;

        conv_a(W_A'(255), 1'b0, "a255");
        conv_a(W_A'(65535), 1'b0, "a65535");
        conv_a(W_A'(0), 1'b0, "a0");
        conv_a(W_A'(1234), 1'b1, "a1234_repulse");
        for (int i = 0; i < 12; i++) conv_a(W_A'($urandom_range(0, 65535)), 1'b0, "a_rand");

        conv_b(W_B'(1000), "b1000");
        conv_b(W_B'(999), "b999");
        conv_b(W_B'(65535), "b65535");
        for (int i = 0; i < 12; i++) conv_b(W_B'($urandom_range(0, 2000)), "b_rand");

        // Abort mid-conversion (dut_a holds a nonzero result beforehand).
        @(negedge clk);
        bin_a   = W_A'(4321);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_bcd", 64'(bcd_a), 64'd0);
        check("abort_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (W_A + 6) begin
            @(negedge clk);
            if (done_a) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_bcd_after", 64'(bcd_a), 64'd0);
        conv_a(W_A'(42), 1'b0, "a42_after_abort");

        // Held start: exhaustive sweep with fixed period.
        @(negedge clk);
        bin_c   = '0;
        start_c = 1'b1;
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            n = 1;
            while (!done_c && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("c_period", 64'(n), (v == 0) ? 64'(W_C + 1) : 64'(W_C + 2));
            check("c_bcd", 64'(bcd_c), ref_bcd(64'(v), D_C));
            check("c_ovf", 64'(ovf_c), 64'(ref_ovf(64'(v), D_C)));
            bin_c = W_C'(v + 1);
        end
        start_c = 1'b0;
        repeat (3) @(negedge clk);
        check("c_idle", 64'(busy_c), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
